// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: header (word count - 1), little-endian words,
// then an 8-bit additive checksum. Each assembled word is strobed out with a one-cycle we.
module imem_loader #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [4:0]   waddr,
  output logic [n-1:0] wdata,
  output logic         we,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StCsum,
    StDone
  } state_e;

  state_e       state_q, state_d;
  logic [4:0]   cnt_q;
  logic [4:0]   widx_q;
  logic [1:0]   bidx_q;
  logic [7:0]   csum_q;
  logic [23:0]  asm_q;
  logic [4:0]   waddr_q;
  logic [n-1:0] wdata_q;
  logic         err_q;
  logic         accept;

  assign accept = rx_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StHdr;
      StHdr:          if (accept) state_d = StData;
      StData:         if (accept && bidx_q == 2'd3) state_d = StWrite;
      StWrite:        state_d = (widx_q == cnt_q) ? StCsum : StData;
      StCsum:         if (accept) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    we       = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StHdr, StData, StCsum: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      StWrite: begin
        busy = 1'b1;
        we   = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Output word/address registers load only when a word completes, so they hold while we=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      csum_q  <= '0;
      asm_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            cnt_q  <= '0;
            widx_q <= '0;
            bidx_q <= '0;
            csum_q <= '0;
            err_q  <= 1'b0;
          end
        end
        StHdr: if (accept) cnt_q <= rx_data[4:0];
        StData: begin
          if (accept) begin
            csum_q <= csum_q + rx_data;
            bidx_q <= bidx_q + 2'd1;
            unique case (bidx_q)
              2'd0: asm_q[7:0]   <= rx_data;
              2'd1: asm_q[15:8]  <= rx_data;
              2'd2: asm_q[23:16] <= rx_data;
              2'd3: begin
                wdata_q <= {rx_data, asm_q};
                waddr_q <= widx_q;
              end
              default: ;
            endcase
          end
        end
        // Saturate so a 32-word load never wraps the index back to 0.
        StWrite: if (widx_q != 5'd31) widx_q <= widx_q + 5'd1;
        StCsum:  if (accept) err_q <= (rx_data != csum_q);
        default: ;
      endcase
    end
  end

  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign err   = err_q;

endmodule
